seq_fetch_ctrl: RTL and testbench

- Parametrised successor to the current program counter and done logic: next-generation fetch sequencer for the 9-bit-instruction core.
- Generates `prog_ctr` for `instr_ROM` and resolves the following in one place:
  - sequential fetch;
  - relative and absolute jumps;
  - flag-conditioned branches on registered `zeroQ` / `pariQ`;
  - subroutine call/return through a hardware return stack;
  - stall, halt and program-end (done) detection.
- Sits between `Control` and `instr_ROM`, replacing the bare PC plus the "`prog_ctr == N`" done compare.

---
 rtl/seq_fetch_ctrl_pkg.sv | 40 ++++
 rtl/seq_fetch_ctrl_ret_stack.sv | 74 +++++++
 rtl/seq_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_seq_fetch_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_fetch_ctrl_pkg.sv
// Shared types and helpers for the fetch sequencer: FSM states, branch
// condition codes, offset sign extension and condition evaluation.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        C_ALWAYS = 2'd0,
        C_Z      = 2'd1,
        C_NZ     = 2'd2,
        C_PAR    = 2'd3
    } cond_t;

    // Sign-extend the low 'width' bits of value to 32 bits.
    function automatic logic [31:0] sext_offset(input logic [31:0] value, input int width);
        logic [31:0] shifted;
        shifted = value << (32 - width);
        return 32'($signed(shifted) >>> (32 - width));
    endfunction

    // True when the branch condition holds for the presented flags.
    function automatic logic cond_true(input logic [1:0] code, input logic zero_flag,
                                       input logic pari_flag);
        logic result;
        case (cond_t'(code))
            C_ALWAYS: result = 1'b1;
            C_Z:      result = zero_flag;
            C_NZ:     result = !zero_flag;
            C_PAR:    result = pari_flag;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seq_fetch_ctrl_ret_stack.sv
// Hardware return-address LIFO. Push writes the slot above the current top,
// pop exposes the next entry down; clear empties it in one cycle. The top
// entry is read combinationally so a return redirects with no extra latency.
module ret_stack #(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]     mem [DEPTH];
    logic [LW-1:0]    level_reg;
    logic [DEPTH-1:0] we;

    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);
    assign level = level_reg;

    // One write enable per slot: only the slot just above the top takes a push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we[gi] = push && !pop && !clear && !full && (level_reg == LW'(gi));
        end
    endgenerate

    // Slot storage; reset wipes every entry so nothing survives an abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we[i]) begin
                    mem[i] <= push_data;
                end
            end
        end
    end

    // Occupancy counter: clear beats pop beats push, so it moves by at most one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_reg <= '0;
        end else if (clear) begin
            level_reg <= '0;
        end else if (pop && !empty) begin
            level_reg <= level_reg - 1'b1;
        end else if (push && !full) begin
            level_reg <= level_reg + 1'b1;
        end
    end

    // Present the current top entry (zero when empty).
    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_reg == LW'(i + 1)) begin
                top_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/seq_fetch_ctrl.sv
// Fetch sequencer for the 9-bit-instruction core. Produces the instruction
// ROM address and resolves sequential fetch, jumps, flag-conditioned branches,
// call/return through the hardware return stack, stall, halt and program end.
module seq_fetch_ctrl
    import seq_pkg::*;
#(
    parameter int D          = 12,
    parameter int OW         = 8,
    parameter int SD         = 4,
    parameter int RESET_ADDR = 0,
    parameter int DONE_ADDR  = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    input  logic                     reljump_en,
    input  logic                     absjump_en,
    input  logic [1:0]               cond,
    input  logic                     zeroQ,
    input  logic                     pariQ,
    input  logic [OW-1:0]            offset,
    input  logic [D-1:0]             target,
    input  logic                     call_en,
    input  logic                     ret_en,
    input  logic                     halt_en,
    output logic [D-1:0]             prog_ctr,
    output logic                     fetch_valid,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(SD+1)-1:0]  sp_level
);

    localparam int LW = $clog2(SD + 1);

    state_t         state_reg, state_next;
    logic [D-1:0]   pc_reg, pc_next;
    logic [D-1:0]   pc_inc, pc_rel;
    logic           cond_ok;

    logic           stk_push, stk_pop, stk_clear;
    logic [D-1:0]   stk_top;
    logic           stk_full, stk_empty;
    logic [LW-1:0]  stk_level;

    // Return addresses are always the instruction after the call.
    ret_stack #(
        .W     (D),
        .DEPTH (SD),
        .LW    (LW)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .clear     (stk_clear),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .level     (stk_level)
    );

    // Both candidate addresses wrap silently modulo 2^D.
    assign pc_inc  = pc_reg + 1'b1;
    assign pc_rel  = pc_reg + D'(sext_offset(32'(offset), OW));
    assign cond_ok = cond_true(cond, zeroQ, pariQ);

    // State and PC registers; reset aborts immediately back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            pc_reg    <= D'(RESET_ADDR);
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Next-state, next-PC and stack requests, resolved in priority order.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_clear  = 1'b0;
        unique case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = D'(RESET_ADDR);
                    stk_clear  = 1'b1;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (halt_en) begin
                        state_next = DONE;
                    end else if (ret_en) begin
                        if (stk_empty) begin
                            state_next = ERR;
                        end else begin
                            stk_pop = 1'b1;
                            pc_next = stk_top;
                        end
                    end else if (call_en) begin
                        if (stk_full) begin
                            state_next = ERR;
                        end else begin
                            stk_push = 1'b1;
                            pc_next  = target;
                        end
                    end else if (absjump_en && cond_ok) begin
                        pc_next = target;
                    end else if (reljump_en && cond_ok) begin
                        pc_next = pc_rel;
                    end else begin
                        pc_next = pc_inc;
                    end
                    // Landing on the end address finishes the program at this edge.
                    if ((state_next == RUN) && (pc_next == D'(DONE_ADDR))) begin
                        state_next = DONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = D'(RESET_ADDR);
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        prog_ctr    = pc_reg;
        fetch_valid = (state_reg == RUN) && !stall;
        done        = (state_reg == DONE);
        err         = (state_reg == ERR);
        sp_level    = stk_level;
    end

endmodule

// File: tb/tb_seq_fetch_ctrl.sv
// Scoreboard bench for seq_fetch_ctrl: a driver applies directed and random
// stimulus, a behavioural model predicts outputs into a queue, and a monitor
// on the falling edge pops and compares against the DUT.
module tb_seq_fetch_ctrl;

    localparam int D    = 12;
    localparam int OW   = 8;
    localparam int SD   = 4;
    localparam int RA   = 0;
    localparam int DA   = 128;
    localparam int LW   = 3;
    localparam int MASK = (1 << D) - 1;

    logic          clk = 1'b0;
    logic          reset, start, stall, reljump_en, absjump_en;
    logic [1:0]    cond;
    logic          zeroQ, pariQ;
    logic [OW-1:0] offset;
    logic [D-1:0]  target;
    logic          call_en, ret_en, halt_en;
    logic [D-1:0]  prog_ctr;
    logic          fetch_valid, done, err;
    logic [LW-1:0] sp_level;

    seq_fetch_ctrl #(
        .D(D), .OW(OW), .SD(SD), .RESET_ADDR(RA), .DONE_ADDR(DA)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .reljump_en(reljump_en), .absjump_en(absjump_en), .cond(cond),
        .zeroQ(zeroQ), .pariQ(pariQ), .offset(offset), .target(target),
        .call_en(call_en), .ret_en(ret_en), .halt_en(halt_en),
        .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .done(done),
        .err(err), .sp_level(sp_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_n; bit start; bit stall; bit rel; bit abs;
        bit [1:0] cond; bit z; bit p; int off; int tgt;
        bit call; bit ret; bit halt;
    } stim_t;

    typedef struct {
        int pc; int fv; int dn; int er; int sp; string tag;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    string cur_tag = "reset";

    // Reference model: mode is "idle", "run", "done" or "trap".
    string m_mode;
    int    m_pc;
    int    m_stack[$];

    function automatic bit cond_holds(bit [1:0] c, bit z, bit p);
        if (c == 2'd0) return 1'b1;
        if (c == 2'd1) return z;
        if (c == 2'd2) return !z;
        return p;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s.rst_n = 1; s.start = 0; s.stall = 0; s.rel = 0; s.abs = 0;
        s.cond = 0; s.z = 0; s.p = 0; s.off = 0; s.tgt = 0;
        s.call = 0; s.ret = 0; s.halt = 0;
        return s;
    endfunction

    task automatic chk(string tag, string name, int act, int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s %s: got %0d expected %0d", tag, name, act, expv);
    endtask

    task automatic model_reset();
        m_mode = "idle";
        m_pc   = RA;
        m_stack.delete();
    endtask

    // Advance the model by one rising edge according to the sequencing rules.
    task automatic model_step(stim_t s);
        if (m_mode != "run") begin
            if (s.start) begin
                m_mode = "run";
                m_pc   = RA;
                m_stack.delete();
            end
        end else if (!s.stall) begin
            if (s.halt) begin
                m_mode = "done";
            end else if (s.ret) begin
                if (m_stack.size() == 0) m_mode = "trap";
                else m_pc = m_stack.pop_back();
            end else if (s.call) begin
                if (m_stack.size() == SD) m_mode = "trap";
                else begin
                    m_stack.push_back((m_pc + 1) & MASK);
                    m_pc = s.tgt;
                end
            end else if (s.abs && cond_holds(s.cond, s.z, s.p)) begin
                m_pc = s.tgt;
            end else if (s.rel && cond_holds(s.cond, s.z, s.p)) begin
                m_pc = (m_pc + s.off) & MASK;
            end else begin
                m_pc = (m_pc + 1) & MASK;
            end
            if (m_mode == "run" && m_pc == DA) m_mode = "done";
        end
    endtask

    // Drive one cycle of stimulus, predict the outputs seen before the next edge.
    task automatic cyc(stim_t s);
        exp_t e;
        reset      = s.rst_n;
        start      = s.start;
        stall      = s.stall;
        reljump_en = s.rel;
        absjump_en = s.abs;
        cond       = s.cond;
        zeroQ      = s.z;
        pariQ      = s.p;
        offset     = OW'(s.off);
        target     = D'(s.tgt);
        call_en    = s.call;
        ret_en     = s.ret;
        halt_en    = s.halt;
        if (!s.rst_n) model_reset();
        e.pc  = m_pc;
        e.fv  = (m_mode == "run" && !s.stall) ? 1 : 0;
        e.dn  = (m_mode == "done") ? 1 : 0;
        e.er  = (m_mode == "trap") ? 1 : 0;
        e.sp  = m_stack.size();
        e.tag = cur_tag;
        sb.push_back(e);
        if (s.rst_n) model_step(s);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT outputs against each predicted entry.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "prog_ctr", int'(prog_ctr), e.pc);
            chk(e.tag, "fetch_valid", int'(fetch_valid), e.fv);
            chk(e.tag, "done", int'(done), e.dn);
            chk(e.tag, "err", int'(err), e.er);
            chk(e.tag, "sp_level", int'(sp_level), e.sp);
        end
    end

    task automatic jump_to(int addr);
        stim_t s;
        s = nop(); s.abs = 1; s.tgt = addr;
        cyc(s);
    endtask

    task automatic call_to(int addr);
        stim_t s;
        s = nop(); s.call = 1; s.tgt = addr;
        cyc(s);
    endtask

    task automatic do_start();
        stim_t s;
        s = nop(); s.start = 1;
        cyc(s);
    endtask

    task automatic idle_n(int n);
        for (int i = 0; i < n; i++) cyc(nop());
    endtask

    task automatic rel_jump(int off, bit [1:0] c, bit z);
        stim_t s;
        s = nop(); s.rel = 1; s.off = off; s.cond = c; s.z = z;
        cyc(s);
    endtask

    initial begin
        stim_t s;
        model_reset();
        s = nop();
        reset = 0; start = 0; stall = 0; reljump_en = 0; absjump_en = 0;
        cond = 0; zeroQ = 0; pariQ = 0; offset = 0; target = 0;
        call_en = 0; ret_en = 0; halt_en = 0;
        @(posedge clk);
        #2;

        cur_tag = "reset";
        s = nop(); s.rst_n = 0;
        cyc(s); cyc(s);
        cur_tag = "idle_ignores";
        s = nop(); s.abs = 1; s.tgt = 77; s.call = 1;
        cyc(s);

        cur_tag = "seq_to_done";
        do_start();
        idle_n(2);
        jump_to(DA - 5);
        idle_n(8);

        cur_tag = "rel_branch";
        do_start();
        jump_to(10);
        rel_jump(-4, 2'd1, 1'b1);
        jump_to(10);
        rel_jump(-4, 2'd1, 1'b0);
        jump_to(2);
        rel_jump(-4, 2'd0, 1'b0);
        cur_tag = "wrap_high";
        idle_n(3);

        cur_tag = "call_ret";
        jump_to(20);
        call_to(100);
        idle_n(3);
        s = nop(); s.ret = 1; cyc(s);

        cur_tag = "overflow";
        jump_to(30);
        call_to(200); call_to(300); call_to(400); call_to(500); call_to(600);
        idle_n(2);
        do_start();
        idle_n(1);

        cur_tag = "underflow";
        s = nop(); s.ret = 1; cyc(s);
        idle_n(1);
        do_start();
        cur_tag = "call_and_ret";
        call_to(50);
        s = nop(); s.call = 1; s.ret = 1; s.tgt = 700; cyc(s);
        idle_n(1);

        cur_tag = "stall";
        s = nop(); s.stall = 1; s.abs = 1; s.tgt = 900;
        cyc(s); cyc(s); cyc(s);
        idle_n(2);

        cur_tag = "async_reset";
        s = nop(); s.rst_n = 0; cyc(s);
        idle_n(1);
        do_start();
        idle_n(1);

        cur_tag = "random";
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 199) != 0);
            s.start = ($urandom_range(0, 9) == 0);
            s.stall = ($urandom_range(0, 99) < 15);
            s.halt  = ($urandom_range(0, 99) < 2);
            s.ret   = ($urandom_range(0, 99) < 10);
            s.call  = ($urandom_range(0, 99) < 12);
            s.abs   = ($urandom_range(0, 99) < 12);
            s.rel   = ($urandom_range(0, 99) < 20);
            s.cond  = 2'($urandom_range(0, 3));
            s.z     = 1'($urandom_range(0, 1));
            s.p     = 1'($urandom_range(0, 1));
            s.off   = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 4) == 0) s.tgt = int'($urandom_range(DA - 3, DA + 3));
            else s.tgt = int'($urandom_range(0, MASK));
            cyc(s);
        end

        @(negedge clk);
        #1;
        chk("end", "scoreboard_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
